// File: rtl/minmax_stream_tracker.sv
// minmax_stream_tracker
//   Framed valid/ready sample stream in, one {min, max, count} result per frame out.
//   Each accepted sample is compared against the held extremes using a full-precision
//   (WIDTH+1)-bit difference, so the compare never overflows.
//
//   Optional build macro: MINMAX_INDEX_EN
//     When defined, the zero-based position of the first occurrence of the min and max
//     is tracked and presented on out_min_idx / out_max_idx.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   clear               synchronous frame abort; wins over every handshake that cycle
//   in_valid/in_ready   sample handshake; in_data sample, in_last marks end of frame
//   out_valid/out_ready result handshake
//   out_min, out_max    frame extremes (held after the result is consumed or cleared)
//   out_count           saturating samples-in-frame count
//   out_min_idx/out_max_idx   index of the extremes (MINMAX_INDEX_EN only)
module minmax_stream_tracker #(
    parameter int WIDTH  = 16,
    parameter int CNT_W  = 8,
    parameter int SIGNED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max,
`ifdef MINMAX_INDEX_EN
    output logic [CNT_W-1:0] out_min_idx,
    output logic [CNT_W-1:0] out_max_idx,
`endif
    output logic [CNT_W-1:0] out_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] min_q, max_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;
    logic             in_lt_min, in_gt_max;
    logic [WIDTH:0]   in_x, min_x, max_x, dmin, dmax;

    // Both handshake outputs decode the state register only, so neither depends on
    // in_* or out_ready combinationally.
    assign in_ready  = (state != S_HOLD);
    assign out_valid = (state == S_HOLD);
    assign accept    = in_valid & in_ready;

    assign out_min   = min_q;
    assign out_max   = max_q;
    assign out_count = cnt_q;

    // Saturating increment; while saturated the count doubles as the capped index.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    // Extend by one bit (sign or zero) so the difference's top bit is the true sign.
    always_comb begin
        in_x  = (SIGNED != 0) ? {in_data[WIDTH-1], in_data} : {1'b0, in_data};
        min_x = (SIGNED != 0) ? {min_q[WIDTH-1], min_q}     : {1'b0, min_q};
        max_x = (SIGNED != 0) ? {max_q[WIDTH-1], max_q}     : {1'b0, max_q};
        dmin  = in_x - min_x;
        dmax  = in_x - max_x;
        // Strict compares: ties keep the earlier value and index.
        in_lt_min = dmin[WIDTH];
        in_gt_max = ~dmax[WIDTH] & (dmax != '0);
    end

`ifdef MINMAX_INDEX_EN
    logic [CNT_W-1:0] min_idx_q, max_idx_q;
    assign out_min_idx = min_idx_q;
    assign out_max_idx = max_idx_q;

    // The pre-increment count is the zero-based position of the incoming sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_idx_q <= '0;
            max_idx_q <= '0;
        end else if (clear) begin
            min_idx_q <= '0;
            max_idx_q <= '0;
        end else if (accept) begin
            if (state == S_IDLE) begin
                min_idx_q <= '0;
                max_idx_q <= '0;
            end else begin
                if (in_lt_min) min_idx_q <= cnt_q;
                if (in_gt_max) max_idx_q <= cnt_q;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            min_q <= '0;
            max_q <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            // Extremes are deliberately left alone; only the frame bookkeeping resets.
            state <= S_IDLE;
            cnt_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    min_q <= in_data;
                    max_q <= in_data;
                    cnt_q <= CNT_W'(1);
                    state <= in_last ? S_HOLD : S_ACCUM;
                end
                S_ACCUM: if (accept) begin
                    if (in_lt_min) min_q <= in_data;
                    if (in_gt_max) max_q <= in_data;
                    cnt_q <= cnt_inc;
                    if (in_last) state <= S_HOLD;
                end
                S_HOLD: if (out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_minmax_stream_tracker.sv
module tb_minmax_stream_tracker;

    logic        clk = 1'b0;
    logic        rst_n, clear, in_valid, in_last, out_ready;
    logic [15:0] in_data;
    // signed instance
    logic        in_ready, out_valid;
    logic [15:0] out_min, out_max;
    logic [7:0]  out_count;
    // unsigned instance (same stimulus, lock-step handshake)
    logic        u_ready, u_valid;
    logic [15:0] u_min, u_max;
    logic [7:0]  u_count;
`ifdef MINMAX_INDEX_EN
    logic [7:0]  out_min_idx, out_max_idx, u_min_idx, u_max_idx;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    minmax_stream_tracker #(.WIDTH(16), .CNT_W(8), .SIGNED(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_min(out_min), .out_max(out_max),
`ifdef MINMAX_INDEX_EN
        .out_min_idx(out_min_idx), .out_max_idx(out_max_idx),
`endif
        .out_count(out_count)
    );

    minmax_stream_tracker #(.WIDTH(16), .CNT_W(8), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(u_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(u_valid), .out_ready(out_ready),
        .out_min(u_min), .out_max(u_max),
`ifdef MINMAX_INDEX_EN
        .out_min_idx(u_min_idx), .out_max_idx(u_max_idx),
`endif
        .out_count(u_count)
    );

    // Inputs change on negedge; one posedge later the sample has been taken.
    task automatic send(input logic [15:0] d, input logic l);
        in_valid = 1'b1; in_data = d; in_last = l;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; in_data = 16'h0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = 16'h0; out_ready = 1'b0;
        #12;
        tests++;
        if ({in_ready, out_valid, out_min, out_max, out_count} !== {1'b1, 1'b0, 16'h0, 16'h0, 8'h0}) begin
            fails++;
            $display("FAIL reset: got rdy=%b vld=%b min=%h max=%h cnt=%0d, want rdy=1 vld=0 min=0 max=0 cnt=0",
                     in_ready, out_valid, out_min, out_max, out_count);
        end
`ifdef MINMAX_INDEX_EN
        tests++;
        if ({out_min_idx, out_max_idx} !== 16'h0) begin
            fails++;
            $display("FAIL reset_idx: got %0d/%0d want 0/0", out_min_idx, out_max_idx);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        send(16'd5, 1'b0);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL basic_midframe_valid: got %b want 0", out_valid);
        end
        send(16'hFFFD, 1'b0);
        send(16'd12, 1'b0);
        send(16'd0, 1'b1);
        tests++;
        if ({out_valid, in_ready, out_min, out_max, out_count} !== {1'b1, 1'b0, 16'hFFFD, 16'h000C, 8'd4}) begin
            fails++;
            $display("FAIL basic_signed: got vld=%b rdy=%b min=%h max=%h cnt=%0d, want vld=1 rdy=0 min=fffd max=000c cnt=4",
                     out_valid, in_ready, out_min, out_max, out_count);
        end
        tests++;
        if ({u_valid, u_min, u_max, u_count} !== {1'b1, 16'h0000, 16'hFFFD, 8'd4}) begin
            fails++;
            $display("FAIL basic_unsigned: got vld=%b min=%h max=%h cnt=%0d, want vld=1 min=0000 max=fffd cnt=4",
                     u_valid, u_min, u_max, u_count);
        end
`ifdef MINMAX_INDEX_EN
        tests++;
        if ({out_min_idx, out_max_idx, u_min_idx, u_max_idx} !== {8'd1, 8'd2, 8'd3, 8'd1}) begin
            fails++;
            $display("FAIL basic_idx: got s=%0d/%0d u=%0d/%0d want s=1/2 u=3/1",
                     out_min_idx, out_max_idx, u_min_idx, u_max_idx);
        end
`endif
        consume();
        tests++;
        if ({out_valid, in_ready, out_min, out_max} !== {1'b0, 1'b1, 16'hFFFD, 16'h000C}) begin
            fails++;
            $display("FAIL basic_consume: got vld=%b rdy=%b min=%h max=%h, want vld=0 rdy=1 min=fffd max=000c",
                     out_valid, in_ready, out_min, out_max);
        end
    endtask

    task automatic test_single();
        send(16'h1234, 1'b1);
        tests++;
        if ({out_valid, out_min, out_max, out_count} !== {1'b1, 16'h1234, 16'h1234, 8'd1}) begin
            fails++;
            $display("FAIL single: got vld=%b min=%h max=%h cnt=%0d, want vld=1 min=1234 max=1234 cnt=1",
                     out_valid, out_min, out_max, out_count);
        end
`ifdef MINMAX_INDEX_EN
        tests++;
        if ({out_min_idx, out_max_idx} !== 16'h0) begin
            fails++; $display("FAIL single_idx: got %0d/%0d want 0/0", out_min_idx, out_max_idx);
        end
`endif
        consume();
    endtask

    task automatic test_overflow_and_backpressure();
        logic [15:0] smin, smax;
        send(16'h7FFF, 1'b0);
        send(16'h8000, 1'b1);
        tests++;
        if ({out_min, out_max} !== {16'h8000, 16'h7FFF}) begin
            fails++; $display("FAIL overflow_signed: got min=%h max=%h want min=8000 max=7fff", out_min, out_max);
        end
        tests++;
        if ({u_min, u_max} !== {16'h7FFF, 16'h8000}) begin
            fails++; $display("FAIL overflow_unsigned: got min=%h max=%h want min=7fff max=8000", u_min, u_max);
        end
        // Backpressure: result must hold and samples offered during HOLD must be ignored.
        smin = out_min; smax = out_max;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; in_data = 16'h0100 + 16'(c); in_last = 1'b1;
            @(negedge clk);
            tests++;
            if ({out_valid, in_ready, out_min, out_max, out_count} !== {1'b1, 1'b0, 16'h8000, 16'h7FFF, 8'd2}) begin
                fails++;
                $display("FAIL backpressure_c%0d: got vld=%b rdy=%b min=%h max=%h cnt=%0d, want vld=1 rdy=0 min=8000 max=7fff cnt=2",
                         c, out_valid, in_ready, out_min, out_max, out_count);
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        if (smin !== 16'h8000 || smax !== 16'h7FFF) begin end
        consume();
        send(16'd3, 1'b1);
        tests++;
        if ({out_valid, out_min, out_max, out_count} !== {1'b1, 16'd3, 16'd3, 8'd1}) begin
            fails++;
            $display("FAIL after_backpressure: got vld=%b min=%h max=%h cnt=%0d, want vld=1 min=0003 max=0003 cnt=1",
                     out_valid, out_min, out_max, out_count);
        end
        consume();
    endtask

    task automatic test_ties();
        send(16'd7, 1'b0);
        send(16'd7, 1'b0);
        send(16'd7, 1'b1);
        tests++;
        if ({out_valid, out_min, out_max, out_count} !== {1'b1, 16'd7, 16'd7, 8'd3}) begin
            fails++;
            $display("FAIL ties: got vld=%b min=%h max=%h cnt=%0d, want vld=1 min=0007 max=0007 cnt=3",
                     out_valid, out_min, out_max, out_count);
        end
`ifdef MINMAX_INDEX_EN
        tests++;
        if ({out_min_idx, out_max_idx} !== 16'h0) begin
            fails++; $display("FAIL ties_idx: got %0d/%0d want 0/0", out_min_idx, out_max_idx);
        end
`endif
        consume();
    endtask

    task automatic test_clear();
        send(16'd100, 1'b0);
        send(16'd50, 1'b0);
        // A last sample presented with clear must be dropped.
        clear = 1'b1; in_valid = 1'b1; in_data = 16'd1; in_last = 1'b1;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        tests++;
        if ({out_valid, in_ready, out_count, out_min, out_max} !== {1'b0, 1'b1, 8'd0, 16'd50, 16'd100}) begin
            fails++;
            $display("FAIL clear_midframe: got vld=%b rdy=%b cnt=%0d min=%h max=%h, want vld=0 rdy=1 cnt=0 min=0032 max=0064",
                     out_valid, in_ready, out_count, out_min, out_max);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL clear_stays_idle: got vld=%b want 0", out_valid);
        end
        send(16'd2, 1'b0);
        send(16'd9, 1'b1);
        tests++;
        if ({out_valid, out_min, out_max, out_count} !== {1'b1, 16'd2, 16'd9, 8'd2}) begin
            fails++;
            $display("FAIL after_clear: got vld=%b min=%h max=%h cnt=%0d, want vld=1 min=0002 max=0009 cnt=2",
                     out_valid, out_min, out_max, out_count);
        end
`ifdef MINMAX_INDEX_EN
        tests++;
        if ({out_min_idx, out_max_idx} !== {8'd0, 8'd1}) begin
            fails++; $display("FAIL after_clear_idx: got %0d/%0d want 0/1", out_min_idx, out_max_idx);
        end
`endif
        // clear while holding a result, with out_ready also high: result is dropped.
        clear = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        clear = 1'b0; out_ready = 1'b0;
        tests++;
        if ({out_valid, in_ready, out_count, out_min, out_max} !== {1'b0, 1'b1, 8'd0, 16'd2, 16'd9}) begin
            fails++;
            $display("FAIL clear_hold: got vld=%b rdy=%b cnt=%0d min=%h max=%h, want vld=0 rdy=1 cnt=0 min=0002 max=0009",
                     out_valid, in_ready, out_count, out_min, out_max);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) send(16'(i), (i == 299));
        tests++;
        if ({out_valid, out_min, out_max, out_count} !== {1'b1, 16'd0, 16'd299, 8'd255}) begin
            fails++;
            $display("FAIL saturation: got vld=%b min=%h max=%h cnt=%0d, want vld=1 min=0000 max=012b cnt=255",
                     out_valid, out_min, out_max, out_count);
        end
`ifdef MINMAX_INDEX_EN
        tests++;
        if ({out_min_idx, out_max_idx} !== {8'd0, 8'd255}) begin
            fails++; $display("FAIL saturation_idx: got %0d/%0d want 0/255", out_min_idx, out_max_idx);
        end
`endif
        consume();
    endtask

    task automatic test_reset_midframe();
        send(16'd40, 1'b0);
        send(16'd60, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({in_ready, out_valid, out_min, out_max, out_count} !== {1'b1, 1'b0, 16'h0, 16'h0, 8'h0}) begin
            fails++;
            $display("FAIL reset_midframe: got rdy=%b vld=%b min=%h max=%h cnt=%0d, want rdy=1 vld=0 min=0 max=0 cnt=0",
                     in_ready, out_valid, out_min, out_max, out_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(16'hFFF0, 1'b1);
        tests++;
        if ({out_valid, out_min, out_max, out_count} !== {1'b1, 16'hFFF0, 16'hFFF0, 8'd1}) begin
            fails++;
            $display("FAIL after_reset_frame: got vld=%b min=%h max=%h cnt=%0d, want vld=1 min=fff0 max=fff0 cnt=1",
                     out_valid, out_min, out_max, out_count);
        end
        consume();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_single();
        test_overflow_and_backpressure();
        test_ties();
        test_clear();
        test_saturation();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
